// File: rtl/onehot_enc4.sv
// onehot_enc4 : registered 4-to-2 encoder for a one-hot 4-line select bus.
//
// The four lines are brought into the clk domain through a two-stage
// synchroniser, then qualified: a pattern is used only after it has been
// seen unchanged for STABLE consecutive samples after it was captured.
// Qualified patterns are classified as IDLE (no line set), LOCKED
// (exactly one line set) or FAULT (two or more lines set), and the
// result is registered together with a one-cycle change strobe.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   en     in   1  output update enable (sync/qualification always run)
//   d      in   4  one-hot select lines, asynchronous to clk
//   code   out  2  index of the highest set qualified line
//   valid  out  1  qualified pattern is exactly one-hot
//   err    out  1  qualified pattern has two or more lines set
//   chg    out  1  one-cycle strobe when {state, code} changes
//   state  out  2  00 IDLE, 01 LOCKED, 10 FAULT
module onehot_enc4 #(
  parameter int STABLE = 3  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] d,
  output logic [1:0] code,
  output logic       valid,
  output logic       err,
  output logic       chg,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_FAULT  = 2'b10
  } state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_cand;
  logic [3:0] r_cnt;
  state_t     r_state;
  logic [1:0] r_code;
  logic       r_valid;
  logic       r_err;
  logic       r_chg;

  logic [2:0] w_pop;
  logic [1:0] w_hi;
  logic       w_qual;
  state_t     w_state_next;
  logic [1:0] w_code_next;
  logic       w_valid_next;
  logic       w_err_next;
  logic       w_chg_next;

  // Synchroniser and stability qualifier. Any difference between the
  // synchronised sample and the held candidate restarts the window, so a
  // glitch that reverts costs a full requalification of the old pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= 4'b0000;
      r_s2   <= 4'b0000;
      r_cand <= 4'b0000;
      r_cnt  <= 4'd0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= 4'd0;
      end else if (r_cnt != STABLE_C) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign w_qual = (r_cnt == STABLE_C);

  // Population count and highest set index of the candidate; the
  // ascending loop lets the highest set line win.
  always_comb begin
    w_pop = 3'd0;
    w_hi  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_pop = w_pop + {2'b00, r_cand[i]};
      if (r_cand[i]) w_hi = 2'(i);
    end
  end

  // Next-state / output logic. Everything holds unless this edge
  // evaluates a qualified pattern with en high.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_valid_next = r_valid;
    w_err_next   = r_err;
    w_chg_next   = 1'b0;
    if (en && w_qual) begin
      if (w_pop == 3'd0) begin
        // IDLE keeps the last code so a released bus still reports
        // where it was.
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
      end else if (w_pop == 3'd1) begin
        w_state_next = ST_LOCKED;
        w_code_next  = w_hi;
        w_valid_next = 1'b1;
        w_err_next   = 1'b0;
      end else begin
        w_state_next = ST_FAULT;
        w_code_next  = w_hi;
        w_valid_next = 1'b0;
        w_err_next   = 1'b1;
      end
      w_chg_next = ({w_state_next, w_code_next} != {r_state, r_code});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= 2'b00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_valid <= w_valid_next;
      r_err   <= w_err_next;
      r_chg   <= w_chg_next;
    end
  end

  assign code  = r_code;
  assign valid = r_valid;
  assign err   = r_err;
  assign chg   = r_chg;
  assign state = r_state;

endmodule

// File: tb/tb_onehot_enc4.sv
module tb_onehot_enc4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] d;
  logic [1:0] code;
  logic       valid;
  logic       err;
  logic       chg;
  logic [1:0] state;

  onehot_enc4 #(.STABLE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d),
    .code  (code),
    .valid (valid),
    .err   (err),
    .chg   (chg),
    .state (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  cd;
    logic        v;
    logic        e;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc     = 0;
  logic        mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected strobe; lat is the number of edges from the drive point.
  task automatic expect_chg(input logic [1:0] st, input logic [1:0] cd,
                            input logic v, input logic e, input int lat);
    exp_t x;
    x.st  = st;
    x.cd  = cd;
    x.v   = v;
    x.e   = e;
    x.cyc = cyc + 32'(lat);
    exp_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [1:0] st, input logic [1:0] cd,
                            input logic v, input logic e);
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".code"},  32'(code),  32'(cd));
    check({name, ".valid"}, 32'(valid), 32'(v));
    check({name, ".err"},   32'(err),   32'(e));
  endtask

  // Monitor: every strobe must match the head of the scoreboard, at the
  // predicted cycle. A strobe lasting two cycles shows up as unexpected.
  always @(negedge clk) begin
    if (mon_en && chg === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_chg", 32'(chg), 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        $display("[TB] chg at cycle %0d: state=%0d code=%0d valid=%0d err=%0d",
                 cyc, state, code, valid, err);
        check("chg.cycle", cyc, x.cyc);
        check("chg.state", 32'(state), 32'(x.st));
        check("chg.code",  32'(code),  32'(x.cd));
        check("chg.valid", 32'(valid), 32'(x.v));
        check("chg.err",   32'(err),   32'(x.e));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    d     = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    check_outs("reset", 2'b00, 2'b00, 1'b0, 1'b0);
    check("reset.chg", 32'(chg), 32'd0);
    mon_en = 1'b1;
    // First qualification of 0000 after reset: IDLE, no strobe.
    tick(10);
    check_outs("idle_after_reset", 2'b00, 2'b00, 1'b0, 1'b0);

    // Lock on each line in turn; 3+STABLE edges plus the sampling edge.
    d = 4'b0001; expect_chg(2'b01, 2'b00, 1'b1, 1'b0, 7); tick(10);
    d = 4'b0010; expect_chg(2'b01, 2'b01, 1'b1, 1'b0, 7); tick(10);
    d = 4'b0100; expect_chg(2'b01, 2'b10, 1'b1, 1'b0, 7); tick(10);
    d = 4'b1000; expect_chg(2'b01, 2'b11, 1'b1, 1'b0, 7); tick(10);
    d = 4'b0001; expect_chg(2'b01, 2'b00, 1'b1, 1'b0, 7); tick(10);

    // Two-cycle glitch is rejected.
    d = 4'b0100; tick(2);
    d = 4'b0001; tick(12);
    check_outs("glitch", 2'b01, 2'b00, 1'b1, 1'b0);

    // Fault with priority, then idle keeps last code.
    d = 4'b0110; expect_chg(2'b10, 2'b10, 1'b0, 1'b1, 7); tick(10);
    d = 4'b0000; expect_chg(2'b00, 2'b10, 1'b0, 1'b0, 7); tick(10);
    check_outs("idle_hold_code", 2'b00, 2'b10, 1'b0, 1'b0);

    // Enable gating.
    d = 4'b0001; expect_chg(2'b01, 2'b00, 1'b1, 1'b0, 7); tick(10);
    en = 1'b0;
    d = 4'b1000; tick(10);
    check_outs("en_low_hold", 2'b01, 2'b00, 1'b1, 1'b0);
    en = 1'b1; expect_chg(2'b01, 2'b11, 1'b1, 1'b0, 1); tick(10);

    // Reset mid-qualification.
    d = 4'b0010; tick(2);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1;
    check_outs("mid_reset", 2'b00, 2'b00, 1'b0, 1'b0);
    check("mid_reset.chg", 32'(chg), 32'd0);
    expect_chg(2'b01, 2'b01, 1'b1, 1'b0, 7);
    tick(12);
    check_outs("after_reset_lock", 2'b01, 2'b01, 1'b1, 1'b0);

    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
